pdm_modulator: RTL and testbench

- Transmit-side counterpart of the PDM microphone decimator: takes 8-bit signed audio samples over a valid/ready handshake and emits a 1-bit PDM stream with its own PDM bit clock.
- Generates the same ~3.125 MHz bit clock that the decimator expects (100 MHz / 32) and holds each sample for exactly NUM_PDM_SAMPLES PDM steps.
- Drives speaker/PWM pins or loops back into the decimator for self-test.

---
 rtl/pdm_pkg.sv | 37 +++
 rtl/pdm_modulator_if.sv | 27 ++
 rtl/pdm_clk_gen.sv | 58 +++++
 rtl/pdm_modulator.sv | 201 ++++++++++++++++++++
 tb/tb_pdm_modulator.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pdm_pkg.sv
// ---------------------------------------------------------------------------
// pdm_pkg
// Shared constants and types for the PDM transmit path (modulator) and the
// matching PDM bit-clock generator.
//   PDM_COUNT_PERIOD_DEF : system clocks per PDM bit (default 32)
//   NUM_PDM_SAMPLES_DEF  : PDM steps per audio sample (default 256)
//   SAMPLE_WIDTH_DEF     : signed audio sample width (default 8)
//   INT_W / INT_MAX      : integrator width and saturation limit used by the
//                          optional second-order loop (SECOND_ORDER_EN)
// ---------------------------------------------------------------------------
package pdm_pkg;

    localparam int PDM_COUNT_PERIOD_DEF = 32;
    localparam int NUM_PDM_SAMPLES_DEF  = 256;
    localparam int SAMPLE_WIDTH_DEF     = 8;

    localparam int INT_W   = 12;
    localparam int INT_MAX = (1 << (INT_W - 1)) - 1;   // 2047, symmetric limit

    typedef logic signed [SAMPLE_WIDTH_DEF-1:0] sample_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pdm_state_t;

    // Clamp a widened integrator sum to +/-INT_MAX.
    function automatic logic signed [INT_W-1:0] sat_int(input logic signed [INT_W+1:0] v);
        if (v > INT_MAX) begin
            return INT_W'(INT_MAX);
        end else if (v < -INT_MAX) begin
            return INT_W'(-INT_MAX);
        end
        return v[INT_W-1:0];
    endfunction

endpackage

// File: rtl/pdm_modulator_if.sv
// ---------------------------------------------------------------------------
// pdm_modulator_if
// Sample handshake between an audio source and the PDM modulator.
//   sample_in        : signed two's-complement audio sample
//   sample_valid_in  : sample_in is valid
//   sample_ready_out : modulator can accept a sample this cycle
// Modports: master = sample source, slave = modulator.
// ---------------------------------------------------------------------------
interface pdm_modulator_if #(
    parameter int SAMPLE_WIDTH = 8
);
    logic [SAMPLE_WIDTH-1:0] sample_in;
    logic                    sample_valid_in;
    logic                    sample_ready_out;

    modport master (
        output sample_in,
        output sample_valid_in,
        input  sample_ready_out
    );

    modport slave (
        input  sample_in,
        input  sample_valid_in,
        output sample_ready_out
    );
endinterface

// File: rtl/pdm_clk_gen.sv
// ---------------------------------------------------------------------------
// pdm_clk_gen
// Divides the system clock down to the PDM bit clock. Shared with the
// receive-side decimator so both ends agree on bit timing.
//   clk_in       : system clock
//   rst_in       : asynchronous active-high reset
//   pdm_clk_out  : registered bit clock, high for the first half of the period
//   pdm_step_out : registered one-cycle strobe, coincident with the
//                  0->1 transition of pdm_clk_out
//   step_next    : combinational "a step is being issued at this edge";
//                  lets the modulator update in the same edge that raises
//                  pdm_step_out, so its outputs line up with the strobe
// ---------------------------------------------------------------------------
module pdm_clk_gen #(
    parameter int PDM_COUNT_PERIOD = 32
) (
    input  logic clk_in,
    input  logic rst_in,
    output logic pdm_clk_out,
    output logic pdm_step_out,
    output logic step_next
);
    localparam int                  DIV_W    = $clog2(PDM_COUNT_PERIOD);
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(PDM_COUNT_PERIOD - 1);
    localparam logic [DIV_W-1:0]    DIV_HALF = DIV_W'(PDM_COUNT_PERIOD / 2);

    logic [DIV_W-1:0] div_cnt_reg;
    logic [DIV_W-1:0] div_cnt_next;
    logic             pdm_clk_reg;
    logic             step_reg;

    always_comb begin
        div_cnt_next = div_cnt_reg + 1'b1;
        if (div_cnt_reg == DIV_LAST) begin
            div_cnt_next = '0;
        end
    end

    // div_cnt==0 is the cycle whose edge flips the bit clock high, so the
    // first step appears one cycle after reset release.
    assign step_next = (div_cnt_reg == '0);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            div_cnt_reg <= '0;
            pdm_clk_reg <= 1'b0;
            step_reg    <= 1'b0;
        end else begin
            div_cnt_reg <= div_cnt_next;
            pdm_clk_reg <= (div_cnt_reg < DIV_HALF);
            step_reg    <= step_next;
        end
    end

    assign pdm_clk_out  = pdm_clk_reg;
    assign pdm_step_out = step_reg;

endmodule

// File: rtl/pdm_modulator.sv
// ---------------------------------------------------------------------------
// pdm_modulator
// Converts signed audio samples into a 1-bit PDM stream with its own bit
// clock. Each accepted sample is held for NUM_PDM_SAMPLES PDM steps.
//   clk_in           : system clock
//   rst_in           : asynchronous active-high reset
//   smp (slave)      : sample_in / sample_valid_in / sample_ready_out
//   pdm_clk_out      : PDM bit clock, 50% duty
//   pdm_step_out     : one-cycle strobe on each bit-clock rising edge
//   pdm_out          : PDM data bit, changes only on step cycles
//   frame_start_out  : one-cycle strobe when a buffered sample becomes current
//   underrun_out     : one-cycle strobe when a frame ends with nothing buffered
//                      (only after the first sample has been played)
// Build option: define SECOND_ORDER_EN for a second-order noise-shaping loop
// with 12-bit saturating integrators; default is a first-order accumulator.
// ---------------------------------------------------------------------------
module pdm_modulator
    import pdm_pkg::*;
#(
    parameter int PDM_COUNT_PERIOD = PDM_COUNT_PERIOD_DEF,
    parameter int NUM_PDM_SAMPLES  = NUM_PDM_SAMPLES_DEF,
    parameter int SAMPLE_WIDTH     = SAMPLE_WIDTH_DEF
) (
    input  logic           clk_in,
    input  logic           rst_in,
    pdm_modulator_if.slave smp,
    output logic           pdm_clk_out,
    output logic           pdm_step_out,
    output logic           pdm_out,
    output logic           frame_start_out,
    output logic           underrun_out
);
    localparam int                STEP_W    = $clog2(NUM_PDM_SAMPLES);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_PDM_SAMPLES - 1);

    logic                           step_next;
    logic [STEP_W-1:0]              step_cnt_reg;
    logic                           boundary;
    logic                           load;
    logic                           accept;

    logic signed [SAMPLE_WIDTH-1:0] next_reg;
    logic                           next_full_reg;
    logic signed [SAMPLE_WIDTH-1:0] current_reg;
    logic                           frame_start_reg;
    logic                           underrun_reg;
    logic                           pdm_reg;

    pdm_state_t                     state_reg;
    pdm_state_t                     state_next;

    // -----------------------------------------------------------------------
    // Bit clock
    // -----------------------------------------------------------------------
    pdm_clk_gen #(
        .PDM_COUNT_PERIOD (PDM_COUNT_PERIOD)
    ) u_clk_gen (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .pdm_clk_out  (pdm_clk_out),
        .pdm_step_out (pdm_step_out),
        .step_next    (step_next)
    );

    // -----------------------------------------------------------------------
    // Handshake and frame timing
    // -----------------------------------------------------------------------
    // Ready comes straight from the buffer flag, so there is no path from
    // valid back to ready. Gated by reset so nothing is taken while held.
    assign smp.sample_ready_out = ~next_full_reg & ~rst_in;
    assign accept               = smp.sample_valid_in & smp.sample_ready_out;

    assign boundary = step_next && (step_cnt_reg == STEP_LAST);
    // next_full_reg is the pre-edge value: an accept in the boundary cycle
    // is not visible here and is played one frame later.
    assign load     = boundary && next_full_reg;

    // -----------------------------------------------------------------------
    // State machine
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (load) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Sample buffer and frame strobes
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            step_cnt_reg    <= '0;
            next_reg        <= '0;
            next_full_reg   <= 1'b0;
            current_reg     <= '0;
            frame_start_reg <= 1'b0;
            underrun_reg    <= 1'b0;
        end else begin
            if (step_next) begin
                step_cnt_reg <= boundary ? '0 : step_cnt_reg + 1'b1;
            end

            if (accept) begin
                next_reg <= smp.sample_in;
            end

            if (load) begin
                next_full_reg <= 1'b0;
            end else if (accept) begin
                next_full_reg <= 1'b1;
            end

            if (load) begin
                current_reg <= next_reg;
            end

            frame_start_reg <= load;
            underrun_reg    <= boundary && !next_full_reg && (state_reg == RUN);
        end
    end

    assign frame_start_out = frame_start_reg;
    assign underrun_out    = underrun_reg;

    // -----------------------------------------------------------------------
    // Modulator core. Uses current_reg as it was before a load in the same
    // edge, so a newly loaded sample shows up from the following step.
    // -----------------------------------------------------------------------
`ifdef SECOND_ORDER_EN
    localparam logic signed [INT_W+1:0] FB_POS = (INT_W+2)'(128);
    localparam logic signed [INT_W+1:0] FB_NEG = -(INT_W+2)'(128);

    logic signed [INT_W-1:0] i1_reg;
    logic signed [INT_W-1:0] i2_reg;
    logic signed [INT_W-1:0] i1_next;
    logic signed [INT_W-1:0] i2_next;
    logic signed [INT_W+1:0] x_ext;
    logic signed [INT_W+1:0] fb_ext;
    logic signed [INT_W+1:0] i1_sum;
    logic signed [INT_W+1:0] i2_sum;
    logic                    bit_next;

    always_comb begin
        bit_next = ~i2_reg[INT_W-1];
        fb_ext   = bit_next ? FB_POS : FB_NEG;
        x_ext    = {{(INT_W+2-SAMPLE_WIDTH){current_reg[SAMPLE_WIDTH-1]}}, current_reg};
        i1_sum   = {{2{i1_reg[INT_W-1]}}, i1_reg} + x_ext - fb_ext;
        i1_next  = sat_int(i1_sum);
        // Second stage integrates the freshly updated first stage.
        i2_sum   = {{2{i2_reg[INT_W-1]}}, i2_reg} + {{2{i1_next[INT_W-1]}}, i1_next} - fb_ext;
        i2_next  = sat_int(i2_sum);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            i1_reg  <= '0;
            i2_reg  <= '0;
            pdm_reg <= 1'b0;
        end else if (step_next) begin
            i1_reg  <= i1_next;
            i2_reg  <= i2_next;
            pdm_reg <= bit_next;
        end
    end
`else
    logic [SAMPLE_WIDTH-1:0] acc_reg;
    logic [SAMPLE_WIDTH-1:0] u_offset;
    logic [SAMPLE_WIDTH:0]   acc_sum;

    always_comb begin
        // Offset binary: flipping the sign bit maps -128..127 onto 0..255,
        // so the carry-out density over a frame equals u_offset/2^width.
        u_offset = {~current_reg[SAMPLE_WIDTH-1], current_reg[SAMPLE_WIDTH-2:0]};
        acc_sum  = {1'b0, acc_reg} + {1'b0, u_offset};
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            acc_reg <= '0;
            pdm_reg <= 1'b0;
        end else if (step_next) begin
            acc_reg <= acc_sum[SAMPLE_WIDTH-1:0];
            pdm_reg <= acc_sum[SAMPLE_WIDTH];
        end
    end
`endif

    assign pdm_out = pdm_reg;

endmodule

// File: tb/tb_pdm_modulator.sv
// ---------------------------------------------------------------------------
// tb_pdm_modulator
// Directed bench for pdm_modulator (default first-order build). A monitor
// tallies per-frame ones, frame starts and underruns; scenario tasks drive
// the sample handshake and compare against hand-computed values.
// ---------------------------------------------------------------------------
module tb_pdm_modulator;
    import pdm_pkg::*;

    localparam int  FRAME_STEPS = 256;
    localparam int  STEP_CYC    = 32;
    localparam time FRAME_TIME  = 81920;   // 8192 cycles of 10 time units

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic pdm_clk_out;
    logic pdm_step_out;
    logic pdm_out;
    logic frame_start_out;
    logic underrun_out;

    always #5 clk_in = ~clk_in;

    pdm_modulator_if smp_if ();

    pdm_modulator dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .smp             (smp_if),
        .pdm_clk_out     (pdm_clk_out),
        .pdm_step_out    (pdm_step_out),
        .pdm_out         (pdm_out),
        .frame_start_out (frame_start_out),
        .underrun_out    (underrun_out)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    // Monitor state
    int   cycle_cnt     = 0;
    int   step_idx      = 0;
    int   last_step_cyc = -1;
    int   hi_cnt        = 0;
    int   period_err    = 0;
    int   hi_err        = 0;
    int   glitch_err    = 0;
    int   fr            = 0;
    logic prev_pdm      = 1'b0;
    int   ones   [16];
    int   fs_n   [16];
    int   ur_n   [16];
    time  fs_t   [16];

    initial begin : monitor
        forever begin
            @(negedge clk_in);
            cycle_cnt++;
            if (rst_in) begin
                step_idx      = 0;
                last_step_cyc = -1;
                hi_cnt        = 0;
                period_err    = 0;
                hi_err        = 0;
                glitch_err    = 0;
                prev_pdm      = pdm_out;
                for (int i = 0; i < 16; i++) begin
                    ones[i] = 0; fs_n[i] = 0; ur_n[i] = 0; fs_t[i] = 0;
                end
            end else begin
                if (pdm_step_out) begin
                    if (last_step_cyc >= 0) begin
                        if (cycle_cnt - last_step_cyc != STEP_CYC) period_err++;
                        if (hi_cnt != STEP_CYC / 2) hi_err++;
                    end
                    last_step_cyc = cycle_cnt;
                    hi_cnt        = 0;
                    step_idx++;
                end else if (pdm_out !== prev_pdm) begin
                    glitch_err++;
                end
                if (pdm_clk_out) hi_cnt++;
                if (step_idx > 0) begin
                    fr = (step_idx - 1) / FRAME_STEPS;
                    if (fr < 16) begin
                        if (pdm_step_out && pdm_out) ones[fr]++;
                        if (frame_start_out) begin fs_n[fr]++; fs_t[fr] = $time; end
                        if (underrun_out) ur_n[fr]++;
                    end
                end
                prev_pdm = pdm_out;
            end
        end
    end

    task automatic wait_steps(input int target);
        int budget;
        int n;
        budget = (target - step_idx) * STEP_CYC + 64;
        n = 0;
        while (step_idx < target && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        n_compared++;
        if (step_idx < target) begin
            n_mismatched++;
            $display("FAIL wait_steps: reached step %0d, required %0d", step_idx, target);
        end
        @(negedge clk_in);
    endtask

    task automatic send_sample(input sample_t val, output time t_acc, output int waited);
        @(negedge clk_in);
        smp_if.sample_in       = val;
        smp_if.sample_valid_in = 1'b1;
        waited = 0;
        while (smp_if.sample_ready_out !== 1'b1 && waited < 10000) begin
            @(negedge clk_in);
            waited++;
        end
        n_compared++;
        if (smp_if.sample_ready_out !== 1'b1) begin
            n_mismatched++;
            $display("FAIL send_timeout: ready=%b after %0d cycles, required 1", smp_if.sample_ready_out, waited);
        end
        t_acc = $time;
        @(posedge clk_in);
        #1;
        smp_if.sample_valid_in = 1'b0;
        $display("send 0x%02h accepted at t=%0t after %0d wait cycles", val, t_acc, waited);
    endtask

    // Reset values, first step timing, idle frames at midscale.
    task automatic test_reset();
        smp_if.sample_in       = '0;
        smp_if.sample_valid_in = 1'b0;
        rst_in = 1'b1;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        n_compared++;
        if ({pdm_clk_out, pdm_step_out, pdm_out, frame_start_out, underrun_out, smp_if.sample_ready_out} !== 6'b0) begin
            n_mismatched++;
            $display("FAIL reset_outputs: got %b required 000000",
                     {pdm_clk_out, pdm_step_out, pdm_out, frame_start_out, underrun_out, smp_if.sample_ready_out});
        end
        rst_in = 1'b0;
        @(negedge clk_in);
        n_compared++;
        if ({pdm_step_out, pdm_clk_out, pdm_out} !== 3'b110) begin
            n_mismatched++;
            $display("FAIL first_step: step/clk/pdm=%b required 110", {pdm_step_out, pdm_clk_out, pdm_out});
        end
        @(negedge clk_in);
        n_compared++;
        if (smp_if.sample_ready_out !== 1'b1) begin
            n_mismatched++;
            $display("FAIL ready_after_reset: got %b required 1", smp_if.sample_ready_out);
        end
        wait_steps(2 * FRAME_STEPS);
        for (int f = 0; f < 2; f++) begin
            n_compared++;
            if (ones[f] != 128 || fs_n[f] != 0 || ur_n[f] != 0) begin
                n_mismatched++;
                $display("FAIL idle_frame%0d: ones=%0d fs=%0d ur=%0d required 128/0/0", f, ones[f], fs_n[f], ur_n[f]);
            end
            $display("idle frame %0d: ones=%0d fs=%0d ur=%0d", f, ones[f], fs_n[f], ur_n[f]);
        end
        n_compared++;
        if (period_err != 0 || hi_err != 0) begin
            n_mismatched++;
            $display("FAIL bit_clock: period_err=%0d hi_err=%0d required 0/0", period_err, hi_err);
        end
    endtask

    // Three samples offered back to back; each later one waits for a frame start.
    task automatic test_back_to_back();
        time t7f, t80, tc0;
        int  w7f, w80, wc0;
        send_sample(sample_t'(8'h7F), t7f, w7f);
        send_sample(sample_t'(8'h80), t80, w80);
        send_sample(sample_t'(8'hC0), tc0, wc0);
        n_compared++;
        if (w7f != 0) begin
            n_mismatched++;
            $display("FAIL b2b_first_wait: waited %0d cycles, required 0", w7f);
        end
        n_compared++;
        if (fs_n[2] != 1 || t80 != fs_t[2]) begin
            n_mismatched++;
            $display("FAIL b2b_second: fs=%0d accept_t=%0t fs_t=%0t required 1 and equal", fs_n[2], t80, fs_t[2]);
        end
        n_compared++;
        if (fs_n[3] != 1 || tc0 != fs_t[3]) begin
            n_mismatched++;
            $display("FAIL b2b_third: fs=%0d accept_t=%0t fs_t=%0t required 1 and equal", fs_n[3], tc0, fs_t[3]);
        end
        n_compared++;
        if (w80 < 100) begin
            n_mismatched++;
            $display("FAIL b2b_ready_low: waited %0d cycles, required >=100", w80);
        end
    endtask

    // Full-scale positive, full-scale negative, then quarter density.
    task automatic test_full_scale();
        int exp_ones [6] = '{128, 128, 128, 255, 0, 64};
        int exp_fs   [6] = '{0, 0, 1, 1, 1, 0};
        wait_steps(6 * FRAME_STEPS);
        for (int f = 2; f < 6; f++) begin
            n_compared++;
            if (ones[f] != exp_ones[f] || fs_n[f] != exp_fs[f]) begin
                n_mismatched++;
                $display("FAIL frame%0d: ones=%0d fs=%0d required %0d/%0d", f, ones[f], fs_n[f], exp_ones[f], exp_fs[f]);
            end
            $display("frame %0d: ones=%0d fs=%0d ur=%0d", f, ones[f], fs_n[f], ur_n[f]);
        end
        n_compared++;
        if (fs_t[3] - fs_t[2] != FRAME_TIME || fs_t[4] - fs_t[3] != FRAME_TIME) begin
            n_mismatched++;
            $display("FAIL frame_spacing: %0t and %0t required %0t", fs_t[3] - fs_t[2], fs_t[4] - fs_t[3], FRAME_TIME);
        end
    endtask

    // Source stops: each boundary reports underrun and the last sample repeats.
    task automatic test_underrun();
        int exp_ur [7] = '{0, 0, 0, 0, 0, 1, 1};
        wait_steps(7 * FRAME_STEPS);
        for (int f = 0; f < 7; f++) begin
            n_compared++;
            if (ur_n[f] != exp_ur[f]) begin
                n_mismatched++;
                $display("FAIL underrun_frame%0d: got %0d required %0d", f, ur_n[f], exp_ur[f]);
            end
        end
        n_compared++;
        if (ones[6] != 64 || fs_n[6] != 0) begin
            n_mismatched++;
            $display("FAIL held_frame: ones=%0d fs=%0d required 64/0", ones[6], fs_n[6]);
        end
        $display("held frame 6: ones=%0d ur=%0d", ones[6], ur_n[6]);
        n_compared++;
        if (glitch_err != 0 || period_err != 0 || hi_err != 0) begin
            n_mismatched++;
            $display("FAIL stream_timing: glitch=%0d period=%0d hi=%0d required 0", glitch_err, period_err, hi_err);
        end
    endtask

    // Reset with a buffered sample while the bit clock and data are high.
    task automatic test_reset_mid_frame();
        time t_acc;
        int  w;
        int  n;
        send_sample(sample_t'(8'h7F), t_acc, w);
        @(negedge clk_in);
        n_compared++;
        if (smp_if.sample_ready_out !== 1'b0) begin
            n_mismatched++;
            $display("FAIL buffer_full_ready: got %b required 0", smp_if.sample_ready_out);
        end
        n = 0;
        while (!(pdm_out === 1'b1 && pdm_clk_out === 1'b1) && n < 4000) begin
            @(negedge clk_in);
            n++;
        end
        n_compared++;
        if (!(pdm_out === 1'b1 && pdm_clk_out === 1'b1)) begin
            n_mismatched++;
            $display("FAIL find_high_point: pdm=%b clk=%b required 1/1", pdm_out, pdm_clk_out);
        end
        rst_in = 1'b1;
        #1;
        n_compared++;
        if ({pdm_clk_out, pdm_step_out, pdm_out, frame_start_out, underrun_out, smp_if.sample_ready_out} !== 6'b0) begin
            n_mismatched++;
            $display("FAIL async_reset: got %b required 000000",
                     {pdm_clk_out, pdm_step_out, pdm_out, frame_start_out, underrun_out, smp_if.sample_ready_out});
        end
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        n_compared++;
        if ({pdm_step_out, pdm_clk_out, pdm_out, smp_if.sample_ready_out} !== 4'b1101) begin
            n_mismatched++;
            $display("FAIL restart_step: step/clk/pdm/ready=%b required 1101",
                     {pdm_step_out, pdm_clk_out, pdm_out, smp_if.sample_ready_out});
        end
        wait_steps(FRAME_STEPS);
        n_compared++;
        if (ones[0] != 128 || fs_n[0] != 0 || ur_n[0] != 0) begin
            n_mismatched++;
            $display("FAIL post_reset_frame: ones=%0d fs=%0d ur=%0d required 128/0/0", ones[0], fs_n[0], ur_n[0]);
        end
        $display("post-reset frame: ones=%0d fs=%0d ur=%0d", ones[0], fs_n[0], ur_n[0]);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_full_scale();
        test_underrun();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
